// File: rtl/apb_uart_multimode.sv
// APB UART slave: runtime 5-8 data bits, optional even/odd parity, 1 or 2 stop bits,
// 16x oversampled fractional baud generator, TX/RX FIFOs, loopback and sticky error flags.
module apb_uart_multimode #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [12:0] BAUD_RESET = 13'd1,
    parameter logic [2:0]  FRAC_RESET = 3'd0,
    parameter logic [7:0]  CTRL_RESET = 8'h03
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [4:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR,
    input  logic       RX,
    output logic       TX,
    output logic       TXRDY,
    output logic       RXRDY,
    output logic       PARITY_ERR,
    output logic       FRAMING_ERR,
    output logic       OVERFLOW,
    output logic [2:0] tx_state_dbg,
    output logic [2:0] rx_state_dbg
);
    localparam int          AW    = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP1, T_STOP2} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_BRK} rx_state_t;

    function automatic logic [7:0] len_mask(input logic [1:0] len);
        return 8'hFF >> (2'd3 - len);
    endfunction

    // Handshake: one transfer per access cycle (PSEL & PENABLE); PREADY is tied high so there
    // are no wait states, and read data is driven combinationally only during that cycle.
    logic acc_wr, acc_rd, stat_rd_q;
    assign acc_wr  = PSEL & PENABLE & PWRITE;
    assign acc_rd  = PSEL & PENABLE & ~PWRITE;
    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

    logic [12:0] baud_div;
    logic [2:0]  frac;
    logic [7:0]  ctrl;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            baud_div  <= BAUD_RESET;
            frac      <= FRAC_RESET;
            ctrl      <= CTRL_RESET;
            stat_rd_q <= 1'b0;
        end else begin
            stat_rd_q <= acc_rd && (PADDR == 5'h14);
            if (acc_wr) begin
                case (PADDR)
                    5'h08:   baud_div[7:0] <= PWDATA;
                    5'h0C:   begin baud_div[12:8] <= PWDATA[4:0]; frac <= PWDATA[7:5]; end
                    5'h10:   ctrl <= PWDATA;
                    default: ;
                endcase
            end
        end
    end

    // Fractional baud: a carry out of the eighths accumulator stretches the next interval by one.
    logic [13:0] brg_cnt;
    logic [2:0]  brg_acc;
    logic [3:0]  brg_sum;
    logic        tick;
    assign brg_sum = {1'b0, brg_acc} + {1'b0, frac};
    assign tick    = (brg_cnt == 14'd0);

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            brg_cnt <= 14'd0;
            brg_acc <= 3'd0;
        end else if (tick) begin
            brg_acc <= brg_sum[2:0];
            brg_cnt <= {1'b0, baud_div} + {13'd0, brg_sum[3]};
        end else begin
            brg_cnt <= brg_cnt - 14'd1;
        end
    end

    // TX FIFO
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wptr, tx_rptr;
    logic [AW:0]   tx_count;
    logic          tx_full, tx_empty, tx_push, tx_pop;
    assign tx_full  = (tx_count == DEPTH);
    assign tx_empty = (tx_count == '0);
    assign tx_push  = acc_wr && (PADDR == 5'h00) && (!tx_full || tx_pop);

    always_ff @(posedge PCLK) if (tx_push) tx_mem[tx_wptr] <= PWDATA;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            tx_wptr <= '0; tx_rptr <= '0; tx_count <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + AW'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
            if (tx_push && !tx_pop)      tx_count <= tx_count + (AW+1)'(1);
            else if (!tx_push && tx_pop) tx_count <= tx_count - (AW+1)'(1);
        end
    end

    // TX FSM; the frame format is captured at pop so CTRL writes only affect later frames
    tx_state_t  tx_state, tx_next;
    logic [7:0] tx_shreg;
    logic [1:0] tx_len;
    logic       tx_par_en, tx_par_bit, tx_two_stop, tx_pend, tx_bit, tx_bit_end;
    logic [3:0] tx_cnt;
    logic [2:0] tx_idx;
    assign tx_bit_end   = tick && (tx_cnt == 4'd15);
    assign tx_state_dbg = tx_state;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) tx_state <= T_IDLE;
        else          tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            T_IDLE:  if (tx_pend && tick) tx_next = T_START;
            T_START: if (tx_bit_end) tx_next = T_DATA;
            T_DATA:  if (tx_bit_end && tx_idx == 3'd4 + {1'b0, tx_len})
                         tx_next = tx_par_en ? T_PAR : T_STOP1;
            T_PAR:   if (tx_bit_end) tx_next = T_STOP1;
            T_STOP1: if (tx_bit_end) tx_next = tx_two_stop ? T_STOP2 : T_IDLE;
            T_STOP2: if (tx_bit_end) tx_next = T_IDLE;
            default: tx_next = T_IDLE;
        endcase
    end

    always_comb begin
        tx_bit = 1'b1;
        case (tx_state)
            T_START: tx_bit = 1'b0;
            T_DATA:  tx_bit = tx_shreg[tx_idx];
            T_PAR:   tx_bit = tx_par_bit;
            default: tx_bit = 1'b1;
        endcase
        tx_pop = (tx_state == T_IDLE) && !tx_pend && !tx_empty;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            tx_shreg <= 8'd0; tx_len <= 2'd0; tx_par_en <= 1'b0; tx_par_bit <= 1'b0;
            tx_two_stop <= 1'b0; tx_pend <= 1'b0; tx_cnt <= 4'd0; tx_idx <= 3'd0;
        end else begin
            if (tx_pop) begin
                tx_shreg    <= tx_mem[tx_rptr] & len_mask(ctrl[1:0]);
                tx_len      <= ctrl[1:0];
                tx_par_en   <= ctrl[2];
                tx_par_bit  <= ^(tx_mem[tx_rptr] & len_mask(ctrl[1:0])) ^ ctrl[3];
                tx_two_stop <= ctrl[4];
                tx_pend     <= 1'b1;
            end
            if (tx_state == T_IDLE && tx_pend && tick) begin
                tx_pend <= 1'b0;
                tx_cnt  <= 4'd0;
                tx_idx  <= 3'd0;
            end else if (tx_state != T_IDLE && tick) begin
                tx_cnt <= tx_cnt + 4'd1;
                if (tx_bit_end && tx_state == T_DATA) tx_idx <= tx_idx + 3'd1;
            end
        end
    end

    assign TX = ctrl[5] ? 1'b1 : tx_bit;

    // RX input: loopback swaps the pin for the internal TX bit ahead of the synchroniser
    logic rx_s1, rx_in, rx_prev, rx_src;
    assign rx_src = ctrl[5] ? tx_bit : RX;
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            rx_s1 <= 1'b1; rx_in <= 1'b1; rx_prev <= 1'b1;
        end else begin
            rx_s1 <= rx_src; rx_in <= rx_s1; rx_prev <= rx_in;
        end
    end

    // RX FIFO
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wptr, rx_rptr;
    logic [AW:0]   rx_count;
    logic          rx_full, rx_empty, rx_push, rx_push_ok, rx_pop;
    logic [7:0]    rx_shreg;
    assign rx_full    = (rx_count == DEPTH);
    assign rx_empty   = (rx_count == '0);
    assign rx_pop     = acc_rd && (PADDR == 5'h04) && !rx_empty;
    assign rx_push_ok = rx_push && (!rx_full || rx_pop);

    always_ff @(posedge PCLK) if (rx_push_ok) rx_mem[rx_wptr] <= rx_shreg;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            rx_wptr <= '0; rx_rptr <= '0; rx_count <= '0;
        end else begin
            if (rx_push_ok) rx_wptr <= rx_wptr + AW'(1);
            if (rx_pop)     rx_rptr <= rx_rptr + AW'(1);
            if (rx_push_ok && !rx_pop)      rx_count <= rx_count + (AW+1)'(1);
            else if (!rx_push_ok && rx_pop) rx_count <= rx_count - (AW+1)'(1);
        end
    end

    // RX FSM
    rx_state_t  rx_state, rx_next;
    logic [3:0] rx_cnt;
    logic [2:0] rx_idx;
    logic       rx_perr, rx_sample, rx_bit_end, rx_fall, pe_evt, fe_evt, ov_evt;
    assign rx_sample    = tick && (rx_cnt == 4'd7);
    assign rx_bit_end   = tick && (rx_cnt == 4'd15);
    assign rx_fall      = rx_prev && !rx_in;
    assign rx_state_dbg = rx_state;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) rx_state <= R_IDLE;
        else          rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:  if (rx_fall) rx_next = R_START;
            R_START: if (rx_sample && rx_in) rx_next = R_IDLE;
                     else if (rx_bit_end)    rx_next = R_DATA;
            R_DATA:  if (rx_bit_end && rx_idx == 3'd4 + {1'b0, ctrl[1:0]})
                         rx_next = ctrl[2] ? R_PAR : R_STOP;
            R_PAR:   if (rx_bit_end) rx_next = R_STOP;
            R_STOP:  if (rx_sample) rx_next = rx_in ? R_IDLE : R_BRK;
            R_BRK:   if (rx_in) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    always_comb begin
        rx_push = (rx_state == R_STOP) && rx_sample;
        fe_evt  = rx_push && !rx_in;
        pe_evt  = rx_push && rx_perr;
        ov_evt  = rx_push && rx_full && !rx_pop;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            rx_cnt <= 4'd0; rx_idx <= 3'd0; rx_shreg <= 8'd0; rx_perr <= 1'b0;
        end else if (rx_state == R_IDLE) begin
            if (rx_fall) begin
                rx_cnt <= 4'd0; rx_idx <= 3'd0; rx_shreg <= 8'd0; rx_perr <= 1'b0;
            end
        end else if (tick && rx_state != R_BRK) begin
            rx_cnt <= rx_cnt + 4'd1;
            if (rx_state == R_DATA && rx_sample)  rx_shreg[rx_idx] <= rx_in;
            if (rx_state == R_DATA && rx_bit_end) rx_idx <= rx_idx + 3'd1;
            if (rx_state == R_PAR && rx_sample)   rx_perr <= (rx_in != (^rx_shreg ^ ctrl[3]));
        end
    end

    // Sticky flags: a new event beats the clear that follows a STATUS read
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            PARITY_ERR <= 1'b0; FRAMING_ERR <= 1'b0; OVERFLOW <= 1'b0;
        end else begin
            PARITY_ERR  <= pe_evt | (PARITY_ERR  & ~stat_rd_q);
            FRAMING_ERR <= fe_evt | (FRAMING_ERR & ~stat_rd_q);
            OVERFLOW    <= ov_evt | (OVERFLOW    & ~stat_rd_q);
        end
    end

    logic tx_idle;
    assign tx_idle = (tx_state == T_IDLE) && tx_empty && !tx_pend;
    assign TXRDY   = !tx_full;
    assign RXRDY   = !rx_empty;

    always_comb begin
        PRDATA = 8'h00;
        if (acc_rd) begin
            case (PADDR)
                5'h04:   PRDATA = rx_empty ? 8'h00 : (rx_mem[rx_rptr] & len_mask(ctrl[1:0]));
                5'h08:   PRDATA = baud_div[7:0];
                5'h0C:   PRDATA = {frac, baud_div[12:8]};
                5'h10:   PRDATA = ctrl;
                5'h14:   PRDATA = {2'b00, tx_idle, FRAMING_ERR, OVERFLOW, PARITY_ERR, RXRDY, TXRDY};
                default: PRDATA = 8'h00;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_uart_multimode.sv
// Directed bench for apb_uart_multimode (FIFO_DEPTH=4): loopback, 7O2 framing, fractional baud,
// framing/parity/overflow errors, TX-full discard and asynchronous reset mid-frame.
module tb_apb_uart_multimode;
    localparam int CYC_BIT = 32;

    logic       PCLK = 1'b0;
    logic       PRESETN = 1'b0;
    logic       PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [4:0] PADDR = 5'd0;
    logic [7:0] PWDATA = 8'd0;
    logic [7:0] PRDATA;
    logic       PREADY, PSLVERR, RX, TX, TXRDY, RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW;
    logic [2:0] tx_state_dbg, rx_state_dbg;
    logic       rx_drv = 1'b1;
    logic       ext_loop = 1'b0;

    assign RX = ext_loop ? TX : rx_drv;

    apb_uart_multimode #(.FIFO_DEPTH(4)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .RX(RX), .TX(TX), .TXRDY(TXRDY), .RXRDY(RXRDY), .PARITY_ERR(PARITY_ERR),
        .FRAMING_ERR(FRAMING_ERR), .OVERFLOW(OVERFLOW),
        .tx_state_dbg(tx_state_dbg), .rx_state_dbg(rx_state_dbg)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    int tx_low_cnt = 0;
    always @(posedge PCLK) cyc++;
    always @(negedge PCLK) if (TX === 1'b0) tx_low_cnt++;

    int n_tests = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [4:0] a, input logic [7:0] d);
        @(posedge PCLK); #1 PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [4:0] a, output logic [7:0] d);
        @(posedge PCLK); #1 PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        #2 d = PRDATA;
        @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic read_check(input logic [4:0] a, input logic [7:0] exp, input string tag);
        logic [7:0] d;
        apb_read(a, d);
        check_eq(tag, 16'(d), 16'(exp));
    endtask

    task automatic read_rx_expect(input string tag);
        logic [7:0] d;
        logic [7:0] e;
        apb_read(5'h04, d);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        check_eq(tag, 16'(d), 16'(e));
    endtask

    task automatic wait_rxrdy(input int max, input string tag);
        int n = 0;
        while (RXRDY !== 1'b1 && n < max) begin @(negedge PCLK); n++; end
        check_eq(tag, 16'(RXRDY), 16'd1);
    endtask

    task automatic wait_tx(input logic v, input int max, input string tag);
        int n = 0;
        while (TX !== v && n < max) begin @(negedge PCLK); n++; end
        check_eq(tag, 16'(TX), 16'(v));
    endtask

    task automatic bit_hold();
        repeat (CYC_BIT) @(posedge PCLK);
        #1;
    endtask

    task automatic send_serial(input logic [7:0] d, input int nbits, input logic par_en,
                               input logic par_val, input logic stop_val);
        rx_drv = 1'b0; bit_hold();
        for (int i = 0; i < nbits; i++) begin rx_drv = d[i]; bit_hold(); end
        if (par_en) begin rx_drv = par_val; bit_hold(); end
        rx_drv = stop_val; bit_hold();
        if (!stop_val) begin bit_hold(); bit_hold(); end
        rx_drv = 1'b1; bit_hold();
    endtask

    // Start edge to fifth rising edge of an 8N1 0x55 frame spans exactly 9 bit times
    task automatic measure_9bits(output int dt);
        int t0;
        wait_tx(1'b0, 2000, "meas_start");
        t0 = cyc;
        for (int k = 0; k < 5; k++) begin
            wait_tx(1'b1, 200, "meas_rise");
            if (k < 4) wait_tx(1'b0, 200, "meas_fall");
        end
        dt = cyc - t0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] bits;
        int dt, low0;

        repeat (3) @(posedge PCLK);
        #1 PRESETN = 1'b1;
        repeat (2) @(negedge PCLK);

        // reset state
        check_eq("rst_tx", 16'(TX), 16'd1);
        check_eq("rst_txrdy", 16'(TXRDY), 16'd1);
        check_eq("rst_rxrdy", 16'(RXRDY), 16'd0);
        check_eq("rst_flags", 16'({PARITY_ERR, FRAMING_ERR, OVERFLOW}), 16'd0);
        check_eq("rst_prdata", 16'(PRDATA), 16'd0);
        check_eq("rst_apb_tie", 16'({PREADY, PSLVERR}), 16'd2);
        read_check(5'h14, 8'h21, "rst_status");
        read_check(5'h10, 8'h03, "rst_ctrl");
        read_check(5'h08, 8'h01, "rst_baudlo");
        read_check(5'h0C, 8'h00, "rst_baudhi");
        read_check(5'h18, 8'h00, "unmapped_read");
        read_check(5'h04, 8'h00, "rx_empty_read");

        // internal loopback 8N1: TX pin must stay high throughout
        apb_write(5'h10, 8'h23);
        low0 = tx_low_cnt;
        apb_write(5'h00, 8'hA5); exp_q.push_back(8'hA5);
        apb_write(5'h00, 8'h3C); exp_q.push_back(8'h3C);
        wait_rxrdy(640, "lb_rx1_timeout");
        read_rx_expect("lb_rx1");
        wait_rxrdy(640, "lb_rx2_timeout");
        repeat (40) @(negedge PCLK);
        read_check(5'h14, 8'h23, "lb_status_full");
        read_rx_expect("lb_rx2");
        read_check(5'h14, 8'h21, "lb_status_drained");
        check_eq("lb_tx_held_high", 16'(tx_low_cnt - low0), 16'd0);

        // 7O2 through an external wire TX->RX
        ext_loop = 1'b1;
        apb_write(5'h10, 8'h1E);
        apb_write(5'h00, 8'hFF);
        wait_tx(1'b0, 200, "7o2_start");
        repeat (16) @(negedge PCLK);
        bits[0] = TX;
        for (int i = 1; i < 12; i++) begin
            repeat (CYC_BIT) @(negedge PCLK);
            bits[i] = TX;
        end
        check_eq("7o2_frame_bits", 16'(bits), 16'h0EFE);
        wait_rxrdy(200, "7o2_rx_timeout");
        read_check(5'h14, 8'h23, "7o2_status");
        read_check(5'h04, 8'h7F, "7o2_rxdata");
        ext_loop = 1'b0;

        // fractional baud: divisor 4 frac 0 -> 80 cycles/bit, frac 4 -> 88 cycles/bit
        apb_write(5'h10, 8'h03);
        apb_write(5'h08, 8'h04);
        apb_write(5'h0C, 8'h00);
        apb_write(5'h00, 8'h55);
        measure_9bits(dt);
        check_eq("div4_9bit_cycles", (dt >= 711 && dt <= 729) ? 16'd720 : 16'(dt), 16'd720);
        repeat (200) @(negedge PCLK);
        apb_write(5'h0C, 8'h80);
        read_check(5'h0C, 8'h80, "baudhi_rb");
        apb_write(5'h00, 8'h55);
        measure_9bits(dt);
        check_eq("frac_9bit_cycles", (dt >= 783 && dt <= 801) ? 16'd792 : 16'(dt), 16'd792);
        repeat (200) @(negedge PCLK);
        apb_write(5'h08, 8'h01);
        apb_write(5'h0C, 8'h00);
        repeat (20) @(negedge PCLK);

        // framing error: stop bit 0 then break, byte still delivered
        send_serial(8'h5A, 8, 1'b0, 1'b0, 1'b0);
        wait_rxrdy(100, "fe_rx_timeout");
        check_eq("fe_pin", 16'(FRAMING_ERR), 16'd1);
        read_check(5'h14, 8'h33, "fe_status_set");
        read_check(5'h14, 8'h23, "fe_status_clr");
        check_eq("fe_pin_clr", 16'(FRAMING_ERR), 16'd0);
        read_check(5'h04, 8'h5A, "fe_rxdata");

        // parity: 8E1 wrong parity then correct parity
        apb_write(5'h10, 8'h07);
        send_serial(8'h01, 8, 1'b1, 1'b0, 1'b1);
        wait_rxrdy(100, "pe_rx_timeout");
        check_eq("pe_pin", 16'(PARITY_ERR), 16'd1);
        read_check(5'h14, 8'h27, "pe_status_set");
        read_check(5'h04, 8'h01, "pe_rxdata");
        send_serial(8'h03, 8, 1'b1, 1'b0, 1'b1);
        wait_rxrdy(100, "pok_rx_timeout");
        read_check(5'h14, 8'h23, "pok_status");
        read_check(5'h04, 8'h03, "pok_rxdata");

        // RX overflow: five frames into a four-entry FIFO
        apb_write(5'h10, 8'h03);
        for (int i = 1; i <= 5; i++) begin
            send_serial(8'(i * 8'h11), 8, 1'b0, 1'b0, 1'b1);
            if (i <= 4) exp_q.push_back(8'(i * 8'h11));
        end
        check_eq("ovf_pin", 16'(OVERFLOW), 16'd1);
        read_check(5'h14, 8'h2B, "ovf_status");
        for (int i = 0; i < 4; i++) read_rx_expect("ovf_rxdata");
        read_check(5'h04, 8'h00, "ovf_fifth_lost");
        read_check(5'h14, 8'h21, "ovf_status_clr");

        // TX FIFO full: sixth write is discarded
        apb_write(5'h10, 8'h23);
        low0 = tx_low_cnt;
        for (int i = 1; i <= 5; i++) begin
            apb_write(5'h00, 8'(8'h80 + i));
            exp_q.push_back(8'(8'h80 + i));
        end
        check_eq("txfull_txrdy", 16'(TXRDY), 16'd0);
        apb_write(5'h00, 8'h86);
        for (int i = 0; i < 5; i++) begin
            wait_rxrdy(700, "txfull_rx_timeout");
            read_rx_expect("txfull_rxdata");
        end
        repeat (700) @(negedge PCLK);
        check_eq("txfull_discarded", 16'(RXRDY), 16'd0);
        check_eq("txfull_lb_tx_high", 16'(tx_low_cnt - low0), 16'd0);

        // asynchronous reset during a TX data bit, TX looped to RX externally
        apb_write(5'h10, 8'h03);
        ext_loop = 1'b1;
        apb_write(5'h00, 8'h00);
        wait_tx(1'b0, 200, "rst_frame_start");
        repeat (48) @(negedge PCLK);
        check_eq("rst_mid_tx_low", 16'(TX), 16'd0);
        #2 PRESETN = 1'b0;
        #1;
        check_eq("rst_async_tx", 16'(TX), 16'd1);
        check_eq("rst_async_rdy", 16'({TXRDY, RXRDY}), 16'd2);
        check_eq("rst_async_flags", 16'({PARITY_ERR, FRAMING_ERR, OVERFLOW}), 16'd0);
        repeat (3) @(posedge PCLK);
        #1 PRESETN = 1'b1;
        repeat (700) @(negedge PCLK);
        check_eq("rst_no_spurious_rx", 16'(RXRDY), 16'd0);
        check_eq("rst_after_tx", 16'(TX), 16'd1);
        read_check(5'h14, 8'h21, "rst_after_status");
        read_check(5'h10, 8'h03, "rst_after_ctrl");
        ext_loop = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
